// File: rtl/clken_sched_pkg.sv
// Shared types and default constants for the clock-enable scheduler.
package clken_sched_pkg;

    localparam int unsigned NREQ_DEF    = 4;
    localparam int unsigned DIV_MAX_DEF = 19;
    localparam int unsigned CNTW_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/clken_sched_if.sv
// Request/grant bundle between requesters (master) and the scheduler (slave).
interface clken_sched_if
    import clken_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned CNTW = CNTW_DEF
);

    logic [NREQ-1:0]      req;
    logic [NREQ*CNTW-1:0] req_len;
    logic [NREQ-1:0]      gnt;
    logic                 tick_en;
    logic [NREQ-1:0]      done;
    logic                 busy;

    modport master (output req, output req_len, input gnt, input tick_en, input done, input busy);
    modport slave  (input req, input req_len, output gnt, output tick_en, output done, output busy);

endinterface

// File: rtl/clken_sched_rr_pick.sv
// Combinational round-robin selector: first set request above ptr, wrapping.
module rr_pick
    import clken_sched_pkg::*;
#(
    parameter  int unsigned NREQ = NREQ_DEF,
    localparam int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            any
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = PW'((32'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/clken_sched.sv
// Round-robin owner of a shared divided clock-enable; emits len ticks per grant,
// then pulses done for that owner.
module clken_sched
    import clken_sched_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEF,
    parameter int unsigned DIV_MAX = DIV_MAX_DEF,
    parameter int unsigned CNTW    = CNTW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    clken_sched_if.slave bus
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned DW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

    sched_state_t    state_q, state_d;
    logic [DW-1:0]   divcnt_q, divcnt_d;
    logic [CNTW-1:0] tickcnt_q, tickcnt_d;
    logic [CNTW-1:0] len_q, len_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            tick_en_q, tick_en_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] win;
    logic            any;
    logic [PW-1:0]   win_idx;
    logic [CNTW-1:0] win_len;
    logic            div_wrap;
    logic            owner_req;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .win (win),
        .any (any)
    );

    // Winner index and its requested burst length
    always_comb begin
        win_idx = '0;
        win_len = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx = PW'(i);
                win_len = bus.req_len[i*CNTW +: CNTW];
            end
        end
    end

    assign div_wrap  = (divcnt_q == DW'(DIV_MAX));
    assign owner_req = |(bus.req & gnt_q);

    // last_q marks the cycle whose end hands over to FIN (last tick, or zero length)
    always_comb begin
        state_d   = state_q;
        divcnt_d  = divcnt_q;
        tickcnt_d = tickcnt_q;
        len_d     = len_q;
        ptr_d     = ptr_q;
        last_d    = 1'b0;
        gnt_d     = gnt_q;
        done_d    = '0;
        tick_en_d = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (any) begin
                    state_d   = RUN;
                    gnt_d     = win;
                    busy_d    = 1'b1;
                    ptr_d     = win_idx;
                    len_d     = win_len;
                    divcnt_d  = '0;
                    tickcnt_d = '0;
                end
            end
            RUN: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (last_q) begin
                    state_d = FIN;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = gnt_q;
                end else begin
                    divcnt_d = div_wrap ? '0 : divcnt_q + DW'(1);
                    if (tick_en_q) begin
                        tickcnt_d = tickcnt_q + CNTW'(1);
                    end
                    tick_en_d = div_wrap && (len_q != '0);
                    last_d    = (len_q == '0) ||
                                (div_wrap && ((tickcnt_d + CNTW'(1)) == len_q));
                end
            end
            FIN: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            divcnt_q  <= '0;
            tickcnt_q <= '0;
            len_q     <= '0;
            ptr_q     <= PW'(NREQ - 1);
            last_q    <= 1'b0;
            gnt_q     <= '0;
            done_q    <= '0;
            tick_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            divcnt_q  <= divcnt_d;
            tickcnt_q <= tickcnt_d;
            len_q     <= len_d;
            ptr_q     <= ptr_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            tick_en_q <= tick_en_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.tick_en = tick_en_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_clken_sched.sv
// Scoreboard bench for clken_sched: expected gnt/tick/done events are queued
// with their cycle stamps as stimulus is applied, and matched as the DUT emits them.
module tb_clken_sched;

    localparam int EV_GNT  = 0;
    localparam int EV_TICK = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] val;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  sb[$];
    logic [3:0] prev_gnt = '0;

    clken_sched_if #(.NREQ(4), .CNTW(8)) bus ();

    clken_sched #(.NREQ(4), .DIV_MAX(19), .CNTW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input logic [3:0] val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic got_ev(input int kind, input logic [3:0] val);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = sb.pop_front();
            chk("ev_kind", 32'(kind), 32'(e.kind));
            chk("ev_cycle", 32'(cyc), 32'(e.cyc));
            chk("ev_value", 32'(val), 32'(e.val));
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_len(input int i, input int v);
        bus.req_len[i*8 +: 8] = 8'(v);
    endtask

    // Output monitor: cycle invariants plus event extraction for the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_vs_gnt", 32'(bus.busy), 32'(|bus.gnt));
            chk("tick_without_gnt", 32'(bus.tick_en && (bus.gnt == 4'b0)), 0);
            chk("done_with_tick", 32'(bus.tick_en && (bus.done != 4'b0)), 0);
            if (bus.gnt != prev_gnt && bus.gnt != 4'b0) got_ev(EV_GNT, bus.gnt);
            if (bus.tick_en) got_ev(EV_TICK, bus.gnt);
            if (bus.done != 4'b0) got_ev(EV_DONE, bus.done);
        end
        prev_gnt = bus.gnt;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int r;
        int own [6] = '{0, 1, 3, 0, 1, 3};

        rst_n       = 1'b0;
        bus.req     = '0;
        bus.req_len = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_tick", 32'(bus.tick_en), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        #3 rst_n = 1'b1;
        wait_cyc(cyc + 2);

        // Round-robin fairness from reset priority
        for (int i = 0; i < 4; i++) set_len(i, 1);
        bus.req = 4'b1011;
        t = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            push_ev(EV_GNT,  t + 23*k,      4'(1 << own[k]));
            push_ev(EV_TICK, t + 23*k + 20, 4'(1 << own[k]));
            push_ev(EV_DONE, t + 23*k + 21, 4'(1 << own[k]));
        end
        wait_cyc(t + 5*23 + 21);
        bus.req = '0;
        wait_cyc(t + 5*23 + 32);
        chk("rr_sb_empty", 32'(sb.size()), 0);

        // Single burst of three ticks
        set_len(0, 3);
        bus.req = 4'b0001;
        t = cyc + 1;
        push_ev(EV_GNT,  t,      4'b0001);
        push_ev(EV_TICK, t + 20, 4'b0001);
        push_ev(EV_TICK, t + 40, 4'b0001);
        push_ev(EV_TICK, t + 60, 4'b0001);
        push_ev(EV_DONE, t + 61, 4'b0001);
        wait_cyc(t);
        chk("single_gnt", 32'(bus.gnt), 32'h1);
        chk("single_busy_on", 32'(bus.busy), 32'h1);
        wait_cyc(t + 61);
        chk("single_done", 32'(bus.done), 32'h1);
        chk("single_busy_off", 32'(bus.busy), 0);
        bus.req = '0;
        wait_cyc(t + 72);
        chk("single_sb_empty", 32'(sb.size()), 0);

        // Zero-length burst
        set_len(2, 0);
        bus.req = 4'b0100;
        t = cyc + 1;
        push_ev(EV_GNT,  t,     4'b0100);
        push_ev(EV_DONE, t + 2, 4'b0100);
        wait_cyc(t);
        chk("zero_gnt", 32'(bus.gnt), 32'h4);
        wait_cyc(t + 2);
        chk("zero_done", 32'(bus.done), 32'h4);
        bus.req = '0;
        wait_cyc(t + 12);
        chk("zero_sb_empty", 32'(sb.size()), 0);

        // Withdrawal mid-burst
        set_len(1, 5);
        bus.req = 4'b0010;
        t = cyc + 1;
        push_ev(EV_GNT,  t,      4'b0010);
        push_ev(EV_TICK, t + 20, 4'b0010);
        push_ev(EV_TICK, t + 40, 4'b0010);
        wait_cyc(t + 45);
        bus.req = '0;
        wait_cyc(t + 46);
        chk("withdraw_gnt", 32'(bus.gnt), 0);
        chk("withdraw_busy", 32'(bus.busy), 0);
        wait_cyc(t + 110);
        chk("withdraw_sb_empty", 32'(sb.size()), 0);

        // Late request from a non-owner waits for the current burst to finish
        set_len(0, 2);
        set_len(2, 1);
        bus.req = 4'b0001;
        t = cyc + 1;
        push_ev(EV_GNT,  t,      4'b0001);
        push_ev(EV_TICK, t + 20, 4'b0001);
        push_ev(EV_TICK, t + 40, 4'b0001);
        push_ev(EV_DONE, t + 41, 4'b0001);
        push_ev(EV_GNT,  t + 43, 4'b0100);
        push_ev(EV_TICK, t + 63, 4'b0100);
        push_ev(EV_DONE, t + 64, 4'b0100);
        wait_cyc(t + 10);
        bus.req = 4'b0101;
        wait_cyc(t + 30);
        chk("arb_hold_gnt", 32'(bus.gnt), 32'h1);
        wait_cyc(t + 41);
        bus.req = 4'b0100;
        wait_cyc(t + 43);
        chk("arb_next_gnt", 32'(bus.gnt), 32'h4);
        wait_cyc(t + 64);
        bus.req = '0;
        wait_cyc(t + 74);
        chk("arb_sb_empty", 32'(sb.size()), 0);

        // Asynchronous reset mid-burst
        set_len(0, 3);
        bus.req = 4'b0001;
        t = cyc + 1;
        push_ev(EV_GNT,  t,      4'b0001);
        push_ev(EV_TICK, t + 20, 4'b0001);
        wait_cyc(t + 30);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(bus.gnt), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_tick", 32'(bus.tick_en), 0);
        chk("arst_done", 32'(bus.done), 0);
        bus.req = '0;
        set_len(0, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        r = cyc;
        wait_cyc(r + 1);
        chk("arst_edge1_gnt", 32'(bus.gnt), 0);
        bus.req = 4'b0001;
        push_ev(EV_GNT,  r + 2,  4'b0001);
        push_ev(EV_TICK, r + 22, 4'b0001);
        push_ev(EV_DONE, r + 23, 4'b0001);
        wait_cyc(r + 2);
        chk("arst_edge2_gnt", 32'(bus.gnt), 32'h1);
        wait_cyc(r + 23);
        bus.req = '0;
        wait_cyc(r + 33);
        chk("arst_sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
